// File: rtl/nand_avalon_sequencer.sv
// Avalon-MM initiator that runs one complete NAND controller register transaction
// per request: optional data write, command write, status polling, optional data read.
module nand_avalon_sequencer #(
    parameter logic [15:0] POLL_MAX = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cmd,
    input  logic        req_has_data,
    input  logic [7:0]  req_data,
    input  logic        req_read,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [7:0]  rsp_status,
    output logic        rsp_timeout,
    output logic [1:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [3:0] {
        IDLE,
        DSETUP,
        DWR,
        CSETUP,
        CWR,
        PSETUP,
        PRD,
        RSETUP,
        RRD,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    state_t      state;
    logic [4:0]  cmd_q;
    logic [7:0]  data_q;
    logic        read_q;
    logic [7:0]  status_q;
    logic [15:0] poll_cnt;

    logic [7:0]  rd_byte;
    logic        status_done;
    logic        poll_limit;
    logic        unused_rd_upper;

    assign rd_byte         = avm_readdata[7:0];
    assign unused_rd_upper = ^avm_readdata[31:8];

    // Done means the controller is not busy (bit 0 low) and the NAND reports ready (bit 1 high).
    assign status_done = !rd_byte[0] && rd_byte[1];
    assign poll_limit  = (POLL_MAX != 16'd0) && ((poll_cnt + 16'd1) == POLL_MAX);

    assign req_ready = (state == IDLE) && !rst;

    // Outputs are registered: each transition loads the bus values the next state must present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= 5'd0;
            data_q        <= 8'd0;
            read_q        <= 1'b0;
            status_q      <= 8'd0;
            poll_cnt      <= 16'd0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'd0;
            rsp_status    <= 8'd0;
            rsp_timeout   <= 1'b0;
            avm_address   <= 2'd0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= 32'd0;
        end else begin
            avm_address   <= 2'd0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= 32'd0;
            rsp_valid     <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd_q       <= req_cmd;
                        data_q      <= req_data;
                        read_q      <= req_read;
                        status_q    <= 8'd0;
                        poll_cnt    <= 16'd0;
                        rsp_data    <= 8'd0;
                        rsp_status  <= 8'd0;
                        rsp_timeout <= 1'b0;
                        if (req_has_data) begin
                            state         <= DSETUP;
                            avm_address   <= ADDR_DATA;
                            avm_writedata <= {24'h0, req_data};
                        end else begin
                            state         <= CSETUP;
                            avm_address   <= ADDR_CMD;
                            avm_writedata <= {27'h0, req_cmd};
                        end
                    end
                end

                DSETUP: begin
                    state         <= DWR;
                    avm_address   <= ADDR_DATA;
                    avm_writedata <= {24'h0, data_q};
                    avm_write     <= 1'b1;
                end

                DWR: begin
                    state         <= CSETUP;
                    avm_address   <= ADDR_CMD;
                    avm_writedata <= {27'h0, cmd_q};
                end

                CSETUP: begin
                    state         <= CWR;
                    avm_address   <= ADDR_CMD;
                    avm_writedata <= {27'h0, cmd_q};
                    avm_write     <= 1'b1;
                end

                CWR: begin
                    state       <= PSETUP;
                    avm_address <= ADDR_STATUS;
                end

                PSETUP: begin
                    state       <= PRD;
                    avm_address <= ADDR_STATUS;
                    avm_read    <= 1'b1;
                end

                // A timeout skips the read phase, so rsp_data stays at the 0 loaded on acceptance.
                PRD: begin
                    status_q <= rd_byte;
                    if (status_done) begin
                        if (read_q) begin
                            state       <= RSETUP;
                            avm_address <= ADDR_DATA;
                        end else begin
                            state      <= DONE;
                            rsp_valid  <= 1'b1;
                            rsp_status <= rd_byte;
                        end
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                        if (poll_limit) begin
                            state       <= DONE;
                            rsp_valid   <= 1'b1;
                            rsp_status  <= rd_byte;
                            rsp_timeout <= 1'b1;
                        end else begin
                            state       <= PSETUP;
                            avm_address <= ADDR_STATUS;
                        end
                    end
                end

                RSETUP: begin
                    state       <= RRD;
                    avm_address <= ADDR_DATA;
                    avm_read    <= 1'b1;
                end

                RRD: begin
                    state      <= DONE;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= rd_byte;
                    rsp_status <= status_q;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_avalon_sequencer.sv
// Scoreboard bench for nand_avalon_sequencer: a scripted register slave answers the
// Avalon accesses, and every response is checked against values queued at request time.
module tb_nand_avalon_sequencer;

    localparam logic [15:0] P = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_cmd = 5'd0;
    logic        req_has_data = 1'b0;
    logic [7:0]  req_data = 8'd0;
    logic        req_read = 1'b0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  rsp_status;
    logic        rsp_timeout;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    nand_avalon_sequencer #(.POLL_MAX(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_has_data  (req_has_data),
        .req_data      (req_data),
        .req_read      (req_read),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .rsp_timeout   (rsp_timeout),
        .avm_address   (avm_address),
        .avm_write     (avm_write),
        .avm_read      (avm_read),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: the first busy_cnt_cfg status reads return busy_val, later ones done_val.
    int         busy_cnt_cfg = 0;
    logic [7:0] busy_val = 8'h01;
    logic [7:0] done_val = 8'h02;
    logic [7:0] data_reg_val = 8'h00;
    int         status_idx = 0;
    int         cyc = 0;

    always_comb begin
        avm_readdata = 32'h0;
        if (avm_read && avm_address == 2'd2)
            avm_readdata = {24'hA5C3F0, (status_idx < busy_cnt_cfg) ? busy_val : done_val};
        else if (avm_read && avm_address == 2'd0)
            avm_readdata = {24'h5A0F3C, data_reg_val};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready)
            status_idx <= 0;
        else if (avm_read && avm_address == 2'd2)
            status_idx <= status_idx + 1;
    end

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  status;
        logic        timeout;
        int          lat;
        int          n_wr0;
        int          n_wr1;
        int          n_rd0;
        int          n_rd2;
        logic [31:0] wd0;
        logic [31:0] wd1;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;

    int          accept_cyc = 0;
    int          o_wr0 = 0, o_wr1 = 0, o_rd0 = 0, o_rd2 = 0, proto_err = 0;
    logic [31:0] o_wd0 = 0, o_wd1 = 0;
    logic        prev_wr = 0, prev_rd = 0;
    logic [1:0]  prev_addr = 0;
    logic [31:0] prev_wd = 0;
    logic        just_accepted = 0, hold_pending = 0;

    // Bus monitor: tallies accesses per transaction, checks setup/strobe pairing, scores responses.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 0; prev_rd = 0; prev_addr = 0; prev_wd = 0;
            just_accepted = 0; hold_pending = 0;
        end else begin
            if (just_accepted) begin
                checkOutput("rsp_clear", {15'h0, rsp_timeout, rsp_status, rsp_data}, 32'h0);
                just_accepted = 0;
            end
            if (hold_pending) begin
                checkOutput("rsp_hold", {14'h0, rsp_valid, rsp_timeout, rsp_status, rsp_data},
                            {14'h0, 1'b0, cur_e.timeout, cur_e.status, cur_e.data});
                hold_pending = 0;
            end
            if (avm_write || avm_read) begin
                if (prev_wr || prev_rd || prev_addr != avm_address || prev_wd != avm_writedata ||
                    (avm_write && avm_read))
                    proto_err++;
                if (avm_write && avm_address == 2'd0) begin
                    if (o_wr1 != 0) proto_err++;
                    o_wr0++; o_wd0 = avm_writedata;
                end
                if (avm_write && avm_address == 2'd1) begin
                    o_wr1++; o_wd1 = avm_writedata;
                end
                if (avm_read && avm_address == 2'd2) o_rd2++;
                if (avm_read && avm_address == 2'd0) begin
                    if (o_rd2 == 0) proto_err++;
                    o_rd0++;
                end
            end
            if (req_ready || rsp_valid)
                checkOutput("idle_bus", avm_writedata | {28'h0, avm_write, avm_read, avm_address}, 32'h0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur_e = exp_q.pop_front();
                    checkOutput("latency", cyc - accept_cyc, cur_e.lat);
                    checkOutput("rsp_data", 32'(rsp_data), 32'(cur_e.data));
                    checkOutput("rsp_status", 32'(rsp_status), 32'(cur_e.status));
                    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(cur_e.timeout));
                    checkOutput("data_writes", o_wr0, cur_e.n_wr0);
                    checkOutput("cmd_writes", o_wr1, cur_e.n_wr1);
                    checkOutput("status_reads", o_rd2, cur_e.n_rd2);
                    checkOutput("data_reads", o_rd0, cur_e.n_rd0);
                    checkOutput("data_wdata", o_wd0, cur_e.wd0);
                    checkOutput("cmd_wdata", o_wd1, cur_e.wd1);
                    checkOutput("bus_protocol", proto_err, 0);
                    hold_pending = 1;
                end
            end
            if (req_valid && req_ready) begin
                accept_cyc = cyc;
                o_wr0 = 0; o_wr1 = 0; o_rd0 = 0; o_rd2 = 0; proto_err = 0;
                o_wd0 = 0; o_wd1 = 0;
                just_accepted = 1;
            end
            prev_wr = avm_write; prev_rd = avm_read;
            prev_addr = avm_address; prev_wd = avm_writedata;
        end
    end

    // Waits for IDLE, configures the slave, presents one request and queues its expected response.
    task automatic applyStimulus(input logic [4:0] cmd, input logic hd, input logic [7:0] d,
                                 input logic rd, input int n_busy, input logic [7:0] bval,
                                 input logic [7:0] dval, input logic [7:0] rdval);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checkOutput("ready_wait", 32'd0, 32'd1);
            return;
        end
        busy_cnt_cfg = n_busy; busy_val = bval; done_val = dval; data_reg_val = rdval;
        req_cmd = cmd; req_has_data = hd; req_data = d; req_read = rd; req_valid = 1'b1;
        if (n_busy >= int'(P)) begin
            e.timeout = 1'b1; e.data = 8'h00; e.status = bval;
            e.lat = 3 + 2 * int'(hd) + 2 * int'(P);
            e.n_rd2 = int'(P); e.n_rd0 = 0;
        end else begin
            e.timeout = 1'b0; e.data = rd ? rdval : 8'h00; e.status = dval;
            e.lat = 5 + 2 * int'(hd) + 2 * int'(rd) + 2 * n_busy;
            e.n_rd2 = n_busy + 1; e.n_rd0 = int'(rd);
        end
        e.n_wr0 = int'(hd); e.n_wr1 = 1;
        e.wd0 = hd ? {24'h0, d} : 32'h0;
        e.wd1 = {27'h0, cmd};
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_cmd = 5'($urandom_range(0, 31));
        req_data = 8'($urandom_range(0, 255));
        req_has_data = 1'($urandom_range(0, 1));
        req_read = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("rsp_wait", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int polls;
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset_wdata", avm_writedata, 32'h0);
        checkOutput("reset_ctl", {24'h0, avm_address, avm_write, avm_read, rsp_valid, rsp_timeout,
                                  req_ready, 1'b0}, 32'h0);
        checkOutput("reset_rsp", {16'h0, rsp_data, rsp_status}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        applyStimulus(5'd9, 1'b0, 8'h00, 1'b0, 0, 8'h01, 8'h02, 8'h77);
        waitDrain();
        applyStimulus(5'd17, 1'b1, 8'hA5, 1'b0, 0, 8'h01, 8'h02, 8'h00);
        waitDrain();
        applyStimulus(5'd16, 1'b0, 8'h00, 1'b1, 3, 8'h01, 8'h02, 8'h3C);
        waitDrain();
        applyStimulus(5'd6, 1'b0, 8'h00, 1'b0, 1000, 8'h01, 8'h02, 8'h99);
        waitDrain();

        applyStimulus(5'd23, 1'b1, 8'h5A, 1'b1, 0, 8'h01, 8'hE2, 8'hC3);
        applyStimulus(5'd1, 1'b0, 8'h00, 1'b1, 2, 8'h00, 8'hFE, 8'h81);
        applyStimulus(5'd2, 1'b1, 8'h33, 1'b0, 3, 8'h03, 8'h02, 8'h00);
        applyStimulus(5'd3, 1'b1, 8'h44, 1'b1, 1000, 8'hFF, 8'h02, 8'h12);
        waitDrain();

        // Abort a request during its second status read.
        applyStimulus(5'd6, 1'b0, 8'h00, 1'b0, 1000, 8'h01, 8'h02, 8'h00);
        polls = 0;
        n = 0;
        while (polls < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (avm_read && avm_address == 2'd2) polls++;
        end
        if (polls < 2) checkOutput("poll_wait", polls, 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_read", 32'(avm_read), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_rsp", {23'h0, rsp_valid, rsp_status}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(5'd16, 1'b1, 8'h5C, 1'b1, 3, 8'h01, 8'h02, 8'hD7);
        waitDrain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
